camo_key_loader: RTL and testbench

//  Serial key-load stage that drives the camouflage select keys (D_0..D_n) of the dummy-wire netlists.

---
 rtl/camo_key_loader.sv | 126 ++++++++++++
 tb/tb_camo_key_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/camo_key_loader.sv
// Serial key loader for the camouflage select keys: receives a parity-protected frame
// bit-serially, holds it in a shadow register and drives key_out only after a commit.
module camo_key_loader #(
  parameter int KEY_W = 2,
  parameter int CNT_W = $clog2(KEY_W + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_sen,
  input  logic             key_sdi,
  input  logic             key_commit,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);

  localparam int FRAME_W = KEY_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_READY,
    S_ERROR,
    S_LOCKED
  } state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] shadow, shadow_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [KEY_W-1:0]   key_nxt;
  logic               valid_nxt, err_nxt, busy_nxt;
  logic               start_frame;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
    state_nxt   = state;
    shadow_nxt  = shadow;
    cnt_nxt     = cnt;
    key_nxt     = key_out;
    valid_nxt   = key_valid;
    err_nxt     = key_err;
    start_frame = 1'b0;

    unique case (state)
      S_IDLE:  start_frame = key_sen;
      S_SHIFT: begin
        if (key_sen) begin
          for (int i = 0; i < FRAME_W; i++) begin
            if (CNT_W'(i) == cnt) shadow_nxt[i] = key_sdi;
          end
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(KEY_W)) state_nxt = S_CHECK;
        end else begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
        end
      end
      S_CHECK: begin
        // Even parity: the XOR over data plus parity bit must be zero.
        if (^shadow) begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (key_commit) begin
          key_nxt   = shadow[KEY_W-1:0];
          valid_nxt = 1'b1;
          state_nxt = S_LOCKED;
        end else begin
          start_frame = key_sen;
        end
      end
      S_ERROR:  start_frame = key_sen;
      S_LOCKED: state_nxt = S_LOCKED;
      default:  state_nxt = S_IDLE;
    endcase

    // A new frame always restarts at bit 0 and discards whatever the shadow held.
    if (start_frame) begin
      shadow_nxt    = '0;
      shadow_nxt[0] = key_sdi;
      cnt_nxt       = CNT_W'(1);
      err_nxt       = 1'b0;
      state_nxt     = S_SHIFT;
    end

    if (key_clear) begin
      shadow_nxt = '0;
      cnt_nxt    = '0;
      key_nxt    = '0;
      valid_nxt  = 1'b0;
      err_nxt    = 1'b0;
      state_nxt  = S_IDLE;
    end

    busy_nxt = (state_nxt == S_SHIFT) || (state_nxt == S_CHECK);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shadow    <= '0;
      cnt       <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      cnt       <= cnt_nxt;
      key_out   <= key_nxt;
      key_valid <= valid_nxt;
      key_err   <= err_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_camo_key_loader.sv
// Self-checking bench for camo_key_loader: directed scenarios plus random traffic,
// compared every cycle against a queue-based frame model.
module tb_camo_key_loader;

  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_sen, key_sdi, key_commit, key_clear;
  logic [KW-1:0] key_out;
  logic          key_valid, key_err, busy;

  int n_vec  = 0;
  int n_miss = 0;

  camo_key_loader #(.KEY_W(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_sen   (key_sen),
    .key_sdi   (key_sdi),
    .key_commit(key_commit),
    .key_clear (key_clear),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_err   (key_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: received bits of the current frame, plus a few flags.
  bit          fr[$];
  bit          chk_pending, rdy, m_err, m_valid;
  logic [KW-1:0] m_key;

  function automatic int frame_sum();
    int s = 0;
    foreach (fr[i]) s += fr[i];
    return s;
  endfunction

  function automatic logic [KW-1:0] frame_key();
    logic [KW-1:0] v = '0;
    for (int i = 0; i < KW; i++) v = v + (KW'(fr[i]) << i);
    return v;
  endfunction

  task automatic model_reset();
    fr.delete();
    chk_pending = 0; rdy = 0; m_err = 0; m_valid = 0; m_key = '0;
  endtask

  task automatic model_step(input bit sen, input bit sdi, input bit commit, input bit clear);
    if (clear) begin
      model_reset();
    end else if (m_valid) begin
      // locked: nothing but clear or reset has an effect
    end else if (chk_pending) begin
      chk_pending = 0;
      if (frame_sum() % 2 == 0) rdy = 1;
      else begin m_err = 1; fr.delete(); end
    end else if (rdy && commit) begin
      m_key = frame_key(); m_valid = 1; rdy = 0; fr.delete();
    end else if (!rdy && fr.size() > 0) begin
      if (sen) begin
        fr.push_back(sdi);
        if (fr.size() == KW + 1) chk_pending = 1;
      end else begin
        m_err = 1; fr.delete();
      end
    end else if (sen) begin
      fr.delete(); fr.push_back(sdi); rdy = 0; m_err = 0;
    end
  endtask

  function automatic bit m_busy();
    return chk_pending || (!rdy && fr.size() > 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("key_out",   32'(key_out),   32'(m_key));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_err",   32'(key_err),   32'(m_err));
    check("busy",      32'(busy),      32'(m_busy()));
  endtask

  // Inputs are set 1ns after an edge, held through the next edge, outputs sampled 1ns later.
  task automatic cyc(input bit sen, input bit sdi, input bit commit = 0, input bit clear = 0);
    key_sen = sen; key_sdi = sdi; key_commit = commit; key_clear = clear;
    @(posedge clk);
    model_step(sen, sdi, commit, clear);
    #1;
    compare_all();
  endtask

  task automatic frame(input bit b0, input bit b1, input bit p);
    cyc(1, b0); cyc(1, b1); cyc(1, p);
  endtask

  // Asserts reset between edges and checks the outputs react without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    key_sen = 0; key_sdi = 0; key_commit = 0; key_clear = 0;
    #1;
    model_reset();
    compare_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    key_sen = 0; key_sdi = 0; key_commit = 0; key_clear = 0;
    model_reset();
    #3;
    compare_all();
    check("rst_key", 32'(key_out), 32'h0);
    rst_n = 1'b1;

    // Good frame 1,0,1 then commit
    frame(1, 0, 1);
    check("t1_busy_check", 32'(busy), 32'h1);
    cyc(0, 0);
    cyc(0, 0, 1);
    check("t1_key", 32'(key_out), 32'h1);
    check("t1_valid", 32'(key_valid), 32'h1);
    cyc(0, 0, 0, 1);

    // Odd-parity frame then a good one
    frame(1, 1, 1);
    cyc(0, 0);
    check("t2_err", 32'(key_err), 32'h1);
    check("t2_key", 32'(key_out), 32'h0);
    frame(0, 1, 1);
    cyc(0, 0);
    cyc(0, 0, 1);
    check("t2_key2", 32'(key_out), 32'h2);
    check("t2_err2", 32'(key_err), 32'h0);
    cyc(0, 0, 0, 1);

    // Aborted frame; later commit ignored
    cyc(1, 1); cyc(1, 0); cyc(0, 0);
    check("t3_err", 32'(key_err), 32'h1);
    check("t3_busy", 32'(busy), 32'h0);
    cyc(0, 0, 1);
    check("t3_valid", 32'(key_valid), 32'h0);

    // Locked key survives a new frame and commit; clear releases it
    frame(1, 0, 1); cyc(0, 0); cyc(0, 0, 1);
    frame(1, 1, 0); cyc(0, 0); cyc(0, 0, 1);
    check("t4_locked", 32'(key_out), 32'h1);
    cyc(0, 0, 0, 1);
    check("t4_clear", 32'(key_out), 32'h0);
    check("t4_clear_valid", 32'(key_valid), 32'h0);

    // Commit and clear together: clear wins
    frame(0, 1, 1); cyc(0, 0);
    cyc(0, 0, 1, 1);
    check("t5_key", 32'(key_out), 32'h0);
    check("t5_valid", 32'(key_valid), 32'h0);

    // Reset mid-frame during bit 1, then an all-zero frame
    cyc(1, 0);
    key_sen = 1; key_sdi = 1;
    #2;
    do_reset();
    check("t6_busy", 32'(busy), 32'h0);
    frame(0, 0, 0); cyc(0, 0); cyc(0, 0, 1);
    check("t6_key", 32'(key_out), 32'h0);
    check("t6_valid", 32'(key_valid), 32'h1);
    cyc(0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(63) == 0) begin
        do_reset();
        @(posedge clk);
        #1;
        compare_all();
      end else begin
        cyc(($urandom_range(3) != 0), 1'($urandom_range(1)),
            ($urandom_range(3) == 0), ($urandom_range(24) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
